pipeline_sequencer: RTL and testbench
=====================================

PIPELINE_SEQUENCER -- requirements
Module: pipeline_sequencer

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 255, range 2..255, which sets the maximum number of frozen cycles allowed while waiting for memory before the block halts.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit, synchronous, active-high.
REQ-004 The block SHALL have port idex_memread, input, 1 bit, meaning the ID/EX instruction is a load (LW/LB).
REQ-005 The block SHALL have port idex_rt, input, 5 bits, the destination register of the ID/EX load.
REQ-006 The block SHALL have ports ifid_rs and ifid_rt, input, 5 bits each, the source registers of the IF/ID instruction.
REQ-007 The block SHALL have port ifid_uses_rt, input, 1 bit, meaning the IF/ID instruction reads rt (R-type, BEQ, BNE, SW).
REQ-008 The block SHALL have port branch_taken, input, 1 bit, meaning a branch resolved taken in EX.
REQ-009 The block SHALL have port jump_id, input, 1 bit, meaning a J instruction is decoded in ID.
REQ-010 The block SHALL have ports mem_req and mem_ready, inputs, 1 bit each, forming the EX/MEM data-memory access handshake.
REQ-011 The block SHALL have outputs pc_write, ifid_write, idex_write, exmem_write, 1 bit each; each is a register load enable.
REQ-012 The block SHALL have outputs ifid_flush, memwb_bubble, ctrl_enable (the enable into the main decoder), 1 bit each.
REQ-013 The block SHALL have outputs mem_timeout (1 bit, sticky) and stall_cycles (16 bits).

Function
REQ-014 The block SHALL implement states RUN, MEM_WAIT, HALT; outputs are combinational from state and inputs.
REQ-015 Default outputs (RUN, no event) SHALL be: all write enables=1, ctrl_enable=1, ifid_flush=0, memwb_bubble=0.
REQ-016 A freeze SHALL drive pc_write=ifid_write=idex_write=exmem_write=0, ctrl_enable=1, ifid_flush=0, and memwb_bubble=1.
REQ-017 In RUN, priority SHALL be: memory wait > branch_taken > jump_id > load-use > default.
REQ-018 Memory wait (mem_req=1, mem_ready=0) in RUN SHALL freeze, load wait_cnt=1, and go to MEM_WAIT.
REQ-019 branch_taken in RUN SHALL drive ifid_flush=1, ctrl_enable=0, pc_write=1, and stay in RUN.
REQ-020 jump_id in RUN SHALL drive ifid_flush=1, pc_write=1, ctrl_enable=1, and stay in RUN.
REQ-021 Load-use SHALL be idex_memread & idex_rt!=0 & (idex_rt==ifid_rs | (ifid_uses_rt & idex_rt==ifid_rt)), and it SHALL drive pc_write=0, ifid_write=0, ctrl_enable=0, one bubble per detection.
REQ-022 In MEM_WAIT with mem_ready=0, the block SHALL freeze; if wait_cnt==TIMEOUT-1 it SHALL set mem_timeout=1 and go to HALT, else increment wait_cnt.
REQ-023 In MEM_WAIT with mem_ready=1, outputs and next state SHALL be evaluated exactly as in RUN with the memory-wait condition false.
REQ-024 HALT SHALL drive all write enables=0, ctrl_enable=0, and memwb_bubble=1 until reset.
REQ-025 stall_cycles SHALL increment on each non-reset cycle with pc_write=0, saturating at 16'hFFFF.
REQ-026 mem_ready=1 without mem_req SHALL be ignored.

Reset
REQ-027 On reset, state SHALL be RUN, and wait_cnt, mem_timeout, and stall_cycles SHALL be 0.
REQ-028 While reset=1, outputs SHALL be: all write enables=0, ctrl_enable=0, ifid_flush=0, memwb_bubble=0.
REQ-029 Reset SHALL take priority in any state, including mid-MEM_WAIT and HALT.

Verification
REQ-030 Load-use: idex_memread=1, idex_rt=5, ifid_rs=5 -> one cycle with pc_write=0, ifid_write=0, ctrl_enable=0; stall_cycles=1.
REQ-031 $0 guard: idex_memread=1, idex_rt=0, ifid_rs=0 -> no stall, default outputs.
REQ-032 Priority: branch_taken=1, jump_id=1, and load-use all in one cycle -> ifid_flush=1, ctrl_enable=0, pc_write=1.
REQ-033 Memory wait: mem_req=1 with mem_ready low for 3 cycles then high -> 3 frozen cycles, release on the 4th, state RUN, stall_cycles=3.
REQ-034 Timeout: TIMEOUT=4, mem_ready held low -> 4 frozen cycles, then HALT with mem_timeout=1; reset -> RUN with counters 0.
REQ-035 Reset in MEM_WAIT: reset asserted on the 2nd wait cycle -> next cycle RUN, wait_cnt=0, outputs at reset values while reset=1.

Source files
------------

// File: rtl/pipeline_sequencer.sv
// Pipeline hazard sequencer: load-use stalls, branch/jump flushes and
// data-memory wait freezing with a timeout that halts the pipeline.
module pipeline_sequencer #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        idex_memread,
    input  logic [4:0]  idex_rt,
    input  logic [4:0]  ifid_rs,
    input  logic [4:0]  ifid_rt,
    input  logic        ifid_uses_rt,
    input  logic        branch_taken,
    input  logic        jump_id,
    input  logic        mem_req,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic        ifid_write,
    output logic        idex_write,
    output logic        exmem_write,
    output logic        ifid_flush,
    output logic        memwb_bubble,
    output logic        ctrl_enable,
    output logic        mem_timeout,
    output logic [15:0] stall_cycles
);

    localparam int unsigned CNT_W     = 8;
    localparam int unsigned STALL_W   = 16;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] wait_cnt_next;
    logic             timeout_hit;
    logic             load_use;
    logic             mem_wait;

    assign load_use = idex_memread && (idex_rt != 5'd0) &&
                      ((idex_rt == ifid_rs) || (ifid_uses_rt && (idex_rt == ifid_rt)));

    // In MEM_WAIT only mem_ready matters; an unrequested ready is ignored in RUN.
    always_comb begin
        mem_wait = 1'b0;
        case (state)
            RUN:      mem_wait = mem_req && !mem_ready;
            MEM_WAIT: mem_wait = !mem_ready;
            default:  mem_wait = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
        end
    end

    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        timeout_hit   = 1'b0;
        case (state)
            RUN: begin
                if (mem_wait) begin
                    state_next    = MEM_WAIT;
                    wait_cnt_next = CNT_W'(1);
                end
            end
            MEM_WAIT: begin
                if (mem_wait) begin
                    if (wait_cnt == CNT_LAST) begin
                        state_next  = HALT;
                        timeout_hit = 1'b1;
                    end else begin
                        wait_cnt_next = wait_cnt + CNT_W'(1);
                    end
                end else begin
                    state_next = RUN;
                end
            end
            HALT:    state_next = HALT;
            default: state_next = RUN;
        endcase
    end

    always_comb begin
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        idex_write   = 1'b1;
        exmem_write  = 1'b1;
        ifid_flush   = 1'b0;
        memwb_bubble = 1'b0;
        ctrl_enable  = 1'b1;
        if (reset) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_write  = 1'b0;
            exmem_write = 1'b0;
            ctrl_enable = 1'b0;
        end else if (state == HALT) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idex_write   = 1'b0;
            exmem_write  = 1'b0;
            ctrl_enable  = 1'b0;
            memwb_bubble = 1'b1;
        end else if (mem_wait) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idex_write   = 1'b0;
            exmem_write  = 1'b0;
            memwb_bubble = 1'b1;
        end else if (branch_taken) begin
            ifid_flush  = 1'b1;
            ctrl_enable = 1'b0;
        end else if (jump_id) begin
            ifid_flush = 1'b1;
        end else if (load_use) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            ctrl_enable = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_timeout  <= 1'b0;
            stall_cycles <= '0;
        end else begin
            mem_timeout <= mem_timeout || timeout_hit;
            if (!pc_write && (stall_cycles != {STALL_W{1'b1}}))
                stall_cycles <= stall_cycles + STALL_W'(1);
        end
    end

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Scoreboard bench for pipeline_sequencer: directed hazard scenarios followed
// by random traffic, checked against a rule-level reference model.
module tb_pipeline_sequencer;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        idex_memread;
    logic [4:0]  idex_rt;
    logic [4:0]  ifid_rs;
    logic [4:0]  ifid_rt;
    logic        ifid_uses_rt;
    logic        branch_taken;
    logic        jump_id;
    logic        mem_req;
    logic        mem_ready;
    logic        pc_write;
    logic        ifid_write;
    logic        idex_write;
    logic        exmem_write;
    logic        ifid_flush;
    logic        memwb_bubble;
    logic        ctrl_enable;
    logic        mem_timeout;
    logic [15:0] stall_cycles;

    pipeline_sequencer #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .idex_memread(idex_memread), .idex_rt(idex_rt),
        .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_uses_rt(ifid_uses_rt),
        .branch_taken(branch_taken), .jump_id(jump_id),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_write(pc_write), .ifid_write(ifid_write), .idex_write(idex_write),
        .exmem_write(exmem_write), .ifid_flush(ifid_flush),
        .memwb_bubble(memwb_bubble), .ctrl_enable(ctrl_enable),
        .mem_timeout(mem_timeout), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       rst;
        logic       memread;
        logic [4:0] rt_ex;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       uses_rt;
        logic       br;
        logic       j;
        logic       req;
        logic       rdy;
    } stim_t;

    // ctl = {pc_write, ifid_write, idex_write, exmem_write, ifid_flush, memwb_bubble, ctrl_enable}
    typedef struct packed {
        logic [6:0]  ctl;
        logic        to;
        logic [15:0] stall;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Reference model state: symbolic phase plus frozen-cycle count.
    typedef enum int {P_RUN, P_WAIT, P_HALT} phase_t;
    phase_t m_phase = P_RUN;
    int     m_frozen = 0;
    bit     m_to = 1'b0;
    int     m_stall = 0;

    task automatic apply(input stim_t s);
        exp_t e;
        bit   waiting;
        bit   hazard;
        @(posedge clk);
        #2;
        reset        = s.rst;
        idex_memread = s.memread;
        idex_rt      = s.rt_ex;
        ifid_rs      = s.rs;
        ifid_rt      = s.rt;
        ifid_uses_rt = s.uses_rt;
        branch_taken = s.br;
        jump_id      = s.j;
        mem_req      = s.req;
        mem_ready    = s.rdy;

        hazard  = s.memread && s.rt_ex != 0 &&
                  (s.rt_ex == s.rs || (s.uses_rt && s.rt_ex == s.rt));
        waiting = (m_phase == P_RUN)  ? (s.req && !s.rdy) :
                  (m_phase == P_WAIT) ? !s.rdy : 1'b0;

        if (s.rst)                  e.ctl = 7'b0000_000;
        else if (m_phase == P_HALT) e.ctl = 7'b0000_010;
        else if (waiting)           e.ctl = 7'b0000_011;
        else if (s.br)              e.ctl = 7'b1111_100;
        else if (s.j)               e.ctl = 7'b1111_101;
        else if (hazard)            e.ctl = 7'b0011_000;
        else                        e.ctl = 7'b1111_001;
        e.to    = m_to;
        e.stall = 16'(m_stall);
        q.push_back(e);

        if (s.rst) begin
            m_phase = P_RUN; m_frozen = 0; m_to = 1'b0; m_stall = 0;
        end else begin
            if (!e.ctl[6] && m_stall < 65535) m_stall++;
            if (m_phase != P_HALT) begin
                if (waiting) begin
                    m_frozen = (m_phase == P_RUN) ? 1 : m_frozen + 1;
                    m_phase  = P_WAIT;
                    if (m_frozen > int'(TO) - 1 + 1 - 1 && m_frozen == int'(TO) + 0 && 1) begin
                        m_phase = P_HALT;
                        m_to    = 1'b1;
                    end
                end else begin
                    m_phase = P_RUN;
                end
            end
        end
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        return s;
    endfunction

    // Monitor: every cycle with an outstanding expectation is compared mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            vectors++;
            if ({pc_write, ifid_write, idex_write, exmem_write, ifid_flush,
                 memwb_bubble, ctrl_enable} !== e.ctl) begin
                miscompares++;
                $display("FAIL ctl t=%0t got=%b want=%b", $time,
                         {pc_write, ifid_write, idex_write, exmem_write,
                          ifid_flush, memwb_bubble, ctrl_enable}, e.ctl);
            end
            vectors++;
            if ({mem_timeout, stall_cycles} !== {e.to, e.stall}) begin
                miscompares++;
                $display("FAIL counters t=%0t got to=%b stall=%0d want to=%b stall=%0d",
                         $time, mem_timeout, stall_cycles, e.to, e.stall);
            end
        end
    end

    initial begin
        stim_t s;
        int    guard;
        reset = 1'b1;
        idex_memread = 0; idex_rt = 0; ifid_rs = 0; ifid_rt = 0; ifid_uses_rt = 0;
        branch_taken = 0; jump_id = 0; mem_req = 0; mem_ready = 0;
        repeat (2) @(posedge clk);

        s = idle(); s.rst = 1; apply(s); apply(s);
        apply(idle());
        // load-use through rs
        s = idle(); s.memread = 1; s.rt_ex = 5; s.rs = 5; apply(s);
        apply(idle());
        // $0 never stalls
        s = idle(); s.memread = 1; s.rt_ex = 0; s.rs = 0; apply(s);
        // branch beats jump and load-use
        s = idle(); s.memread = 1; s.rt_ex = 5; s.rs = 5; s.br = 1; s.j = 1; apply(s);
        s = idle(); s.j = 1; s.memread = 1; s.rt_ex = 7; s.rs = 7; apply(s);
        // load-use through rt only when rt is read
        s = idle(); s.memread = 1; s.rt_ex = 9; s.rs = 3; s.rt = 9; s.uses_rt = 1; apply(s);
        s.uses_rt = 0; apply(s);
        // memory wait of 3 cycles then release
        s = idle(); s.req = 1; repeat (3) apply(s);
        s.rdy = 1; apply(s);
        s = idle(); s.rdy = 1; apply(s);
        apply(idle());
        // timeout into HALT, then recovery by reset
        s = idle(); s.req = 1; s.br = 1; repeat (6) apply(s);
        s = idle(); s.rst = 1; apply(s);
        apply(idle());
        // reset mid-wait restarts the wait count
        s = idle(); s.req = 1; apply(s);
        s.rst = 1; apply(s);
        s.rst = 0; repeat (5) apply(s);
        s = idle(); s.rst = 1; apply(s);

        for (int i = 0; i < 3000; i++) begin
            s.rst     = ($urandom_range(0, 63) == 0);
            s.memread = $urandom_range(0, 1);
            s.rt_ex   = 5'($urandom_range(0, 3));
            s.rs      = 5'($urandom_range(0, 3));
            s.rt      = 5'($urandom_range(0, 3));
            s.uses_rt = $urandom_range(0, 1);
            s.br      = ($urandom_range(0, 5) == 0);
            s.j       = ($urandom_range(0, 5) == 0);
            s.req     = ($urandom_range(0, 3) == 0);
            s.rdy     = ($urandom_range(0, 2) != 0);
            apply(s);
        end

        guard = 0;
        while (q.size() > 0 && guard < 20) begin
            @(posedge clk);
            guard++;
        end
        if (q.size() > 0) begin
            miscompares++;
            $display("FAIL drain pending=%0d want=0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
